// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute payload, aligns and extends SRAM load data,
// and drives the write-back and forwarding buses. Optional misaligned-load check: MEM_MISALIGN_CHK_EN.
module mem_stage #(
   parameter int unsigned IN_W  = 112,
   parameter int unsigned OUT_W = 70
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [IN_W-1:0]  EXE_to_MEM_BUS,
   input  logic             EXE_to_MEM_valid,
   input  logic             WB_allowin,
   output logic             MEM_allowin,
   output logic             MEM_to_WB_valid,
   output logic [OUT_W-1:0] MEM_to_WB_BUS,
   output logic [36:0]      MEM_RF_BUS,
   input  logic [31:0]      data_sram_rdata,
   output logic             mem_ale
);

   logic [IN_W-1:0] bus_latch;
   logic            mem_valid;
   logic            first;
   logic [31:0]     rdata_hold;
   logic            accept;

   logic [31:0] pc;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] exe_result;
   logic [31:0] st_data;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [3:0]  load_op;
   logic        rfrom_mem;

   logic [31:0] rdata_eff;
   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_value;
   logic [31:0] final_result;
   logic        ld_w;
   logic        gr_we_eff;
   logic        unused_fields;

   assign {pc, gr_we, dest, exe_result, st_data, mem_en, mem_we, load_op, rfrom_mem} = bus_latch;
   // Store-side fields were already consumed by the SRAM request in execute.
   assign unused_fields = ^{st_data, mem_en, mem_we};

   assign MEM_allowin     = !mem_valid || WB_allowin;
   assign MEM_to_WB_valid = mem_valid;
   assign accept          = EXE_to_MEM_valid && MEM_allowin;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_valid  <= 1'b0;
         first      <= 1'b0;
         rdata_hold <= 32'd0;
         bus_latch  <= '0;
      end else begin
         if (MEM_allowin) begin
            mem_valid <= EXE_to_MEM_valid;
         end
         first <= accept;
         // SRAM data is only presented in the first MEM cycle; keep it for stalls.
         if (first) begin
            rdata_hold <= data_sram_rdata;
         end
         if (accept) begin
            bus_latch <= EXE_to_MEM_BUS;
         end
      end
   end

   assign rdata_eff = first ? data_sram_rdata : rdata_hold;
   assign off       = exe_result[1:0];
   assign ld_w      = rfrom_mem && (load_op == 4'd0);

   always_comb begin
      ld_byte = rdata_eff[7:0];
      case (off)
         2'd0:    ld_byte = rdata_eff[7:0];
         2'd1:    ld_byte = rdata_eff[15:8];
         2'd2:    ld_byte = rdata_eff[23:16];
         default: ld_byte = rdata_eff[31:24];
      endcase
      ld_half = off[1] ? rdata_eff[31:16] : rdata_eff[15:0];

      load_value = rdata_eff;
      if (load_op[3]) begin
         load_value = {{24{ld_byte[7]}}, ld_byte};
      end else if (load_op[2]) begin
         load_value = {{16{ld_half[15]}}, ld_half};
      end else if (load_op[1]) begin
         load_value = {24'd0, ld_byte};
      end else if (load_op[0]) begin
         load_value = {16'd0, ld_half};
      end
   end

   assign final_result = rfrom_mem ? load_value : exe_result;

`ifdef MEM_MISALIGN_CHK_EN
   assign mem_ale = mem_valid && rfrom_mem &&
                    (((load_op[2] || load_op[0]) && off[0]) || (ld_w && (off != 2'd0)));
   assign gr_we_eff = gr_we && !mem_ale;
`else
   assign mem_ale   = 1'b0;
   assign gr_we_eff = gr_we;
`endif

   assign MEM_to_WB_BUS = {pc, gr_we_eff, dest, final_result};
   assign MEM_RF_BUS    = {{5{gr_we_eff && mem_valid}} & dest, final_result};

endmodule
